// File: rtl/data_bus_bridge_pkg.sv
// Shared datapath constants and types for the core data-bus bridge.
//   bridgeState_t : bridge FSM state encoding (IDLE, REQ, DONE)
//   memCmd_t      : latched slave command (we, byte lanes, address, write data)
//   DefaultErrData: read data returned to the core when the slave times out
package data_bus_bridge_pkg;

    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;
    localparam int unsigned BeW   = 4;

    localparam logic [DataW-1:0] DefaultErrData = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } bridgeState_t;

    typedef struct packed {
        logic             we;
        logic [BeW-1:0]   be;
        logic [AddrW-1:0] addr;
        logic [DataW-1:0] wdata;
    } memCmd_t;

endpackage

// File: rtl/data_bus_bridge_watchdog.sv
// bus_watchdog: saturating REQ-cycle counter for the data-bus bridge.
//   iCLK, iRST : clock, synchronous active-high reset
//   clear      : force the count back to zero (outside the REQ phase)
//   enable     : count one more un-acknowledged REQ cycle
//   expired    : registered flag, high while count == TIMEOUT-1
module bus_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned     CntW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);
    localparam logic [CntW-1:0] Limit  = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] count;
    logic [CntW-1:0] countNext;

    // Saturate at TIMEOUT so a stuck enable can never wrap back to zero.
    always_comb begin
        countNext = count;
        if (clear) begin
            countNext = '0;
        end else if (enable && (count != CntMax)) begin
            countNext = count + CntW'(1);
        end
    end

    // expired is registered from the next count so it lines up with count.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            count   <= '0;
            expired <= (Limit == '0);
        end else begin
            count   <= countNext;
            expired <= (countNext == Limit);
        end
    end

endmodule

// File: rtl/data_bus_bridge.sv
// data_bus_bridge: turns the core's single-cycle data-bus strobes into a
// req/ack handshake toward data memory / MMIO, stalling the core meanwhile.
//   iCLK, iRST                 : clock, synchronous active-high reset
//   iReadEnable, iWriteEnable  : core load/store strobes (write wins if both)
//   iByteEnable, iAddress,
//   iWriteData                 : core access payload
//   oReadData                  : load data (ERR_DATA on timeout, held on writes)
//   oStall                     : core hold; combinational from strobes in IDLE
//   oBusError                  : one-cycle pulse when the slave times out
//   oMemReq/We/Be/Addr/WData   : registered slave request, held through REQ
//   iMemAck, iMemRData         : slave completion and read data
module data_bus_bridge
    import data_bus_bridge_pkg::*;
#(
    parameter int unsigned      TIMEOUT  = 255,
    parameter logic [DataW-1:0] ERR_DATA = DefaultErrData
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iReadEnable,
    input  logic             iWriteEnable,
    input  logic [BeW-1:0]   iByteEnable,
    input  logic [AddrW-1:0] iAddress,
    input  logic [DataW-1:0] iWriteData,
    output logic [DataW-1:0] oReadData,
    output logic             oStall,
    output logic             oBusError,
    output logic             oMemReq,
    output logic             oMemWe,
    output logic [BeW-1:0]   oMemBe,
    output logic [AddrW-1:0] oMemAddr,
    output logic [DataW-1:0] oMemWData,
    input  logic             iMemAck,
    input  logic [DataW-1:0] iMemRData
);

    bridgeState_t state;
    memCmd_t      cmd;
    logic         anyStrobe;
    logic         wdClear;
    logic         wdEnable;
    logic         wdExpired;

    assign anyStrobe = iReadEnable | iWriteEnable;

    // Count only un-acknowledged REQ cycles; every other state restarts it.
    assign wdClear  = (state != REQ);
    assign wdEnable = (state == REQ) && !iMemAck;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) uWatchdog (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .clear   (wdClear),
        .enable  (wdEnable),
        .expired (wdExpired)
    );

    // Bridge FSM; the slave command is captured once on leaving IDLE.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= IDLE;
            cmd       <= '0;
            oMemReq   <= 1'b0;
            oReadData <= '0;
            oBusError <= 1'b0;
        end else begin
            oBusError <= 1'b0;
            case (state)
                IDLE: begin
                    if (anyStrobe) begin
                        cmd.we    <= iWriteEnable;
                        cmd.be    <= iByteEnable;
                        cmd.addr  <= iAddress;
                        cmd.wdata <= iWriteData;
                        oMemReq   <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    // Ack takes priority over a coinciding timeout.
                    if (iMemAck) begin
                        if (!cmd.we) begin
                            oReadData <= iMemRData;
                        end
                        oMemReq <= 1'b0;
                        state   <= DONE;
                    end else if (wdExpired) begin
                        oReadData <= ERR_DATA;
                        oBusError <= 1'b1;
                        oMemReq   <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    oMemReq <= 1'b0;
                end
            endcase
        end
    end

    assign oMemWe    = cmd.we;
    assign oMemBe    = cmd.be;
    assign oMemAddr  = cmd.addr;
    assign oMemWData = cmd.wdata;

    // Stall must assert in the same cycle the strobe appears.
    always_comb begin
        oStall = 1'b0;
        case (state)
            IDLE:    oStall = anyStrobe;
            REQ:     oStall = 1'b1;
            default: oStall = 1'b0;
        endcase
    end

endmodule
